// File: rtl/cram_port_arbiter.sv
// cram_port_arbiter
//   Schedules the single-port cart-RAM SRAM controller between the CPU/mapper
//   byte path (cpu_*), the savestate byte path (ss_*) and the save-file backup
//   word path (bk_*). Each access is a fixed four-state transaction
//   IDLE -> ISSUE -> WAIT -> DONE, so request-to-ack latency is 3 cycles.
//   Priority is cpu > ss > bk, except that a bk request which has watched
//   AGE_MAX cpu/ss grants go by wins the next arbitration.
//
// Ports
//   clk_sys, reset          system clock, synchronous active-high reset
//   cpu_req/we/addr/d       CPU request (level), byte address, write data
//   cpu_q, cpu_ack          CPU read byte, one-cycle completion pulse
//   ss_req/we/addr/d        savestate request, byte address, write data
//   ss_q, ss_ack            savestate read byte, completion pulse
//   bk_req/we/addr/d        backup request, word address, write word
//   bk_q, bk_ack            backup read word, completion pulse
//   mem_addr/d/we/ub/lb     SRAM controller command (word address, lanes)
//   mem_q                   SRAM read data, valid two cycles after ISSUE
//   busy                    high during ISSUE, WAIT and DONE
module cram_port_arbiter #(
   parameter int AGE_MAX = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [16:0] cpu_addr,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   output logic        cpu_ack,
   input  logic        ss_req,
   input  logic        ss_we,
   input  logic [16:0] ss_addr,
   input  logic [7:0]  ss_d,
   output logic [7:0]  ss_q,
   output logic        ss_ack,
   input  logic        bk_req,
   input  logic        bk_we,
   input  logic [15:0] bk_addr,
   input  logic [15:0] bk_d,
   output logic [15:0] bk_q,
   output logic        bk_ack,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_d,
   output logic        mem_we,
   output logic        mem_ub,
   output logic        mem_lb,
   input  logic [15:0] mem_q,
   output logic        busy
);

   localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic [1:0] {SEL_CPU, SEL_SS, SEL_BK} sel_t;

   state_t      state, state_nxt;
   sel_t        sel, win;
   logic        any_req;
   logic        win_we, win_lsb, win_bk;
   logic [15:0] win_word, win_d;
   logic        we_l, lsb_l;
   logic [2:0]  age;
   logic [7:0]  byte_q;

   assign any_req = cpu_req | ss_req | bk_req;
   assign win_bk  = (win == SEL_BK);
   assign byte_q  = lsb_l ? mem_q[15:8] : mem_q[7:0];

   // Winner selection and its command fields. Byte ports replicate the data
   // on both lanes; the lane enables pick the half that actually gets written.
   always_comb begin
      win      = SEL_CPU;
      win_we   = cpu_we;
      win_word = cpu_addr[16:1];
      win_lsb  = cpu_addr[0];
      win_d    = {cpu_d, cpu_d};
      if (bk_req && age == AGE_LIM) win = SEL_BK;
      else if (cpu_req)             win = SEL_CPU;
      else if (ss_req)              win = SEL_SS;
      else if (bk_req)              win = SEL_BK;
      case (win)
         SEL_SS: begin
            win_we   = ss_we;
            win_word = ss_addr[16:1];
            win_lsb  = ss_addr[0];
            win_d    = {ss_d, ss_d};
         end
         SEL_BK: begin
            win_we   = bk_we;
            win_word = bk_addr;
            win_lsb  = 1'b0;
            win_d    = bk_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered command/response path. The mem_addr/mem_d registers double as
   // the latched address/data of the transaction, so they simply hold after
   // ISSUE.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sel      <= SEL_CPU;
         we_l     <= 1'b0;
         lsb_l    <= 1'b0;
         age      <= 3'd0;
         mem_addr <= 16'd0;
         mem_d    <= 16'd0;
         mem_we   <= 1'b0;
         mem_ub   <= 1'b0;
         mem_lb   <= 1'b0;
         cpu_ack  <= 1'b0;
         ss_ack   <= 1'b0;
         bk_ack   <= 1'b0;
         cpu_q    <= 8'd0;
         ss_q     <= 8'd0;
         bk_q     <= 16'd0;
         busy     <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         ss_ack  <= 1'b0;
         bk_ack  <= 1'b0;
         case (state)
            IDLE: if (any_req) begin
               sel      <= win;
               we_l     <= win_we;
               lsb_l    <= win_lsb;
               mem_addr <= win_word;
               mem_d    <= win_d;
               mem_we   <= win_we;
               mem_ub   <= win_we & (win_bk | win_lsb);
               mem_lb   <= win_we & (win_bk | ~win_lsb);
               busy     <= 1'b1;
               // age counts only grants that bk had to watch go past it
               if (win_bk || !bk_req) age <= 3'd0;
               else if (age < AGE_LIM) age <= age + 3'd1;
            end
            ISSUE: begin
               mem_we <= 1'b0;
               mem_ub <= 1'b0;
               mem_lb <= 1'b0;
            end
            WAIT: begin
               case (sel)
                  SEL_CPU: cpu_ack <= 1'b1;
                  SEL_SS:  ss_ack  <= 1'b1;
                  default: bk_ack  <= 1'b1;
               endcase
            end
            DONE: begin
               busy <= 1'b0;
               // mem_q is valid in this cycle; writes leave *_q untouched
               if (!we_l) begin
                  case (sel)
                     SEL_CPU: cpu_q <= byte_q;
                     SEL_SS:  ss_q  <= byte_q;
                     default: bk_q  <= mem_q;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cram_port_arbiter.sv
module tb_cram_port_arbiter;
   localparam int AGE_MAX = 4;
   localparam int P_CPU = 0;
   localparam int P_SS  = 1;
   localparam int P_BK  = 2;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [16:0] cpu_addr = '0;
   logic [7:0]  cpu_d = '0;
   logic [7:0]  cpu_q;
   logic        cpu_ack;
   logic        ss_req = 1'b0, ss_we = 1'b0;
   logic [16:0] ss_addr = '0;
   logic [7:0]  ss_d = '0;
   logic [7:0]  ss_q;
   logic        ss_ack;
   logic        bk_req = 1'b0, bk_we = 1'b0;
   logic [15:0] bk_addr = '0, bk_d = '0;
   logic [15:0] bk_q;
   logic        bk_ack;
   logic [15:0] mem_addr, mem_d, mem_q;
   logic        mem_we, mem_ub, mem_lb, busy;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      int          port;
      logic [15:0] q;
   } sb_t;
   sb_t         sb[$];
   logic [15:0] exp_q [0:2];

   always #5 clk_sys = ~clk_sys;

   cram_port_arbiter #(.AGE_MAX(AGE_MAX)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
      .cpu_q(cpu_q), .cpu_ack(cpu_ack),
      .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_d(ss_d),
      .ss_q(ss_q), .ss_ack(ss_ack),
      .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_d(bk_d),
      .bk_q(bk_q), .bk_ack(bk_ack),
      .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we), .mem_ub(mem_ub),
      .mem_lb(mem_lb), .mem_q(mem_q), .busy(busy)
   );

   // SRAM controller model: lane-masked writes, two-cycle registered reads
   logic [15:0] sram [0:65535];
   logic [15:0] rd_s1;
   always @(posedge clk_sys) begin
      if (mem_we) begin
         if (mem_ub) sram[mem_addr][15:8] <= mem_d[15:8];
         if (mem_lb) sram[mem_addr][7:0]  <= mem_d[7:0];
      end
      rd_s1 <= sram[mem_addr];
      mem_q <= rd_s1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] qof(input int p);
      case (p)
         P_CPU:   return {24'b0, cpu_q};
         P_SS:    return {24'b0, ss_q};
         default: return {16'b0, bk_q};
      endcase
   endfunction

   task automatic exp_push(input int p, input logic we, input logic [15:0] rdv);
      sb_t e;
      if (!we) exp_q[p] = rdv;
      e.port = p;
      e.q    = exp_q[p];
      sb.push_back(e);
   endtask

   task automatic post(input int p, input logic we, input logic [16:0] addr,
                       input logic [15:0] d, input logic [15:0] rdv);
      case (p)
         P_CPU: begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_d = d[7:0]; end
         P_SS:  begin ss_req = 1'b1; ss_we = we; ss_addr = addr; ss_d = d[7:0]; end
         default: begin bk_req = 1'b1; bk_we = we; bk_addr = addr[15:0]; bk_d = d; end
      endcase
      exp_push(p, we, rdv);
   endtask

   task automatic drop(input int p);
      case (p)
         P_CPU:   cpu_req = 1'b0;
         P_SS:    ss_req  = 1'b0;
         default: bk_req  = 1'b0;
      endcase
   endtask

   // Wait (bounded) for the next ack, compare with the scoreboard head, then
   // check the ack was a single pulse and the port's read register one cycle on.
   task automatic get_ack(input string tag, input int exp_lat, input bit drop_it);
      int  lat;
      int  port;
      sb_t e;
      lat  = 0;
      port = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_sys);
         if (cpu_ack | ss_ack | bk_ack) begin
            lat = c;
            if (cpu_ack)     port = P_CPU;
            else if (ss_ack) port = P_SS;
            else             port = P_BK;
            break;
         end
      end
      if (sb.size() == 0) begin
         e.port = -2;
         e.q    = 16'h0;
      end else begin
         e = sb.pop_front();
      end
      chk({tag, " port"}, port, e.port);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " onehot"}, $countones({cpu_ack, ss_ack, bk_ack}), (port >= 0) ? 1 : 0);
      if (drop_it && port >= 0) drop(port);
      @(negedge clk_sys);
      chk({tag, " ack_single"}, {cpu_ack, ss_ack, bk_ack}, 0);
      chk({tag, " q"}, qof(e.port), e.q);
   endtask

   int acks;

   initial begin
      for (int i = 0; i < 3; i++) exp_q[i] = 16'h0;

      // reset state
      repeat (3) @(negedge clk_sys);
      chk("rst acks", {cpu_ack, ss_ack, bk_ack}, 0);
      chk("rst mem_ctl", {mem_we, mem_ub, mem_lb}, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_d", mem_d, 0);
      chk("rst cpu_q", cpu_q, 0);
      chk("rst ss_q", ss_q, 0);
      chk("rst bk_q", bk_q, 0);
      chk("rst busy", busy, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      // preload word 1 = 0xBEEF through the bk port
      post(P_BK, 1'b1, 17'h00001, 16'hBEEF, 16'h0);
      @(negedge clk_sys);
      chk("bkw1 issue ctl", {mem_we, mem_ub, mem_lb}, 3'b111);
      chk("bkw1 addr", mem_addr, 16'h0001);
      chk("bkw1 d", mem_d, 16'hBEEF);
      chk("bkw1 busy", busy, 1);
      @(negedge clk_sys);
      chk("bkw1 wait we", mem_we, 0);
      get_ack("bkw1", 1, 1);

      // single CPU read of the upper byte
      post(P_CPU, 1'b0, 17'h00003, 16'h0, 16'h00BE);
      @(negedge clk_sys);
      chk("cpurd issue ctl", {mem_we, mem_ub, mem_lb}, 3'b000);
      chk("cpurd addr", mem_addr, 16'h0001);
      @(negedge clk_sys);
      get_ack("cpurd", 1, 1);

      // CPU write of the low byte of word 1
      post(P_CPU, 1'b1, 17'h00002, 16'h005A, 16'h0);
      @(negedge clk_sys);
      chk("cpuwr issue ctl", {mem_we, mem_ub, mem_lb}, 3'b101);
      chk("cpuwr addr", mem_addr, 16'h0001);
      chk("cpuwr d", mem_d, 16'h5A5A);
      @(negedge clk_sys);
      chk("cpuwr wait ctl", {mem_we, mem_ub, mem_lb}, 3'b000);
      chk("cpuwr wait addr", mem_addr, 16'h0001);
      get_ack("cpuwr", 1, 1);
      post(P_CPU, 1'b0, 17'h00002, 16'h0, 16'h005A);
      get_ack("cpurd2", 3, 1);

      // request dropped during ISSUE still completes (upper byte untouched)
      post(P_CPU, 1'b0, 17'h00003, 16'h0, 16'h00BE);
      @(negedge clk_sys);
      drop(P_CPU);
      get_ack("cpudrop", 2, 0);

      // bk write then bk read of word 0x10
      post(P_BK, 1'b1, 17'h00010, 16'h1234, 16'h0);
      @(negedge clk_sys);
      chk("bkw issue ctl", {mem_we, mem_ub, mem_lb}, 3'b111);
      chk("bkw addr", mem_addr, 16'h0010);
      get_ack("bkw", 2, 1);
      post(P_BK, 1'b0, 17'h00010, 16'h0, 16'h1234);
      get_ack("bkr", 3, 1);

      // simultaneous requests: cpu, ss, bk at cycles 3, 7, 11
      post(P_CPU, 1'b0, 17'h00002, 16'h0, 16'h005A);
      post(P_SS,  1'b0, 17'h00021, 16'h0, 16'h0012);
      post(P_BK,  1'b0, 17'h00010, 16'h0, 16'h1234);
      get_ack("sim0", 3, 1);
      get_ack("sim1", 3, 1);
      get_ack("sim2", 3, 1);

      // ageing: cpu and bk both held; bk wins every fifth grant
      cpu_we = 1'b0; cpu_addr = 17'h00002; cpu_req = 1'b1;
      bk_we  = 1'b0; bk_addr  = 16'h0010;  bk_req  = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < AGE_MAX; i++) exp_push(P_CPU, 1'b0, 16'h005A);
         exp_push(P_BK, 1'b0, 16'h1234);
      end
      for (int i = 0; i < 2 * (AGE_MAX + 1); i++) get_ack($sformatf("age%0d", i), 3, 0);
      cpu_req = 1'b0;
      bk_req  = 1'b0;
      @(negedge clk_sys);
      chk("age idle busy", busy, 0);

      // reset during WAIT of a CPU read
      cpu_we = 1'b0; cpu_addr = 17'h00002; cpu_req = 1'b1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("rstw busy", busy, 1);
      reset   = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk_sys);
      chk("rstw acks", {cpu_ack, ss_ack, bk_ack}, 0);
      chk("rstw mem_ctl", {mem_we, mem_ub, mem_lb}, 0);
      chk("rstw mem_addr", mem_addr, 0);
      chk("rstw mem_d", mem_d, 0);
      chk("rstw cpu_q", cpu_q, 0);
      chk("rstw bk_q", bk_q, 0);
      chk("rstw busy", busy, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) exp_q[i] = 16'h0;
      acks = 0;
      repeat (6) begin
         @(negedge clk_sys);
         if (cpu_ack | ss_ack | bk_ack) acks++;
      end
      chk("rstw no ack", acks, 0);
      post(P_CPU, 1'b0, 17'h00002, 16'h0, 16'h005A);
      get_ack("post_rst", 3, 1);
      chk("sb empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cram_port_arbiter.md
# cram_port_arbiter

Sequences the single-port cartridge-RAM SRAM controller between three requesters: the CPU/mapper cart-RAM path, the save-file backup path (bk load/store) and the savestate CRAM path. It replaces the per-signal muxing in front of the SRAM controller with an explicit request/acknowledge scheduler. Requesters are arbitrated by fixed priority with an ageing override so the backup path cannot be starved. Each access is one fixed-latency transaction.

## Interface
Parameters:
- `AGE_MAX`, 4: number of CPU/SS grants a pending bk request tolerates before it is forced to win.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req` / `cpu_we`  in  1 / 1  CPU request (level, held until ack); write when `cpu_we`=1.
- `cpu_addr` / `cpu_d`  in  17 / 8  CPU byte address / write data.
- `cpu_q` / `cpu_ack`  out  8 / 1  CPU read data / one-cycle completion pulse.
- `ss_req` / `ss_we`  in  1 / 1  savestate request (level) / write.
- `ss_addr` / `ss_d`  in  17 / 8  savestate byte address / write data.
- `ss_q` / `ss_ack`  out  8 / 1  savestate read data / completion pulse.
- `bk_req` / `bk_we`  in  1 / 1  backup request (level) / write.
- `bk_addr` / `bk_d`  in  16 / 16  backup word address / write data.
- `bk_q` / `bk_ack`  out  16 / 1  backup read word / completion pulse.
- `mem_addr` / `mem_d`  out  16 / 16  SRAM controller word address / write data.
- `mem_we`, `mem_ub`, `mem_lb`  out  1 each  write strobe and byte-lane enables.
- `mem_q`  in  16  SRAM controller read data (registered, valid 2 cycles after issue).
- `busy`  out  1  high while a transaction is in flight.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Every transaction traverses all four in order; there is no early exit.
- IDLE: when any request is high, latch the winner, its `we`, address and data; go to ISSUE. With no request, stay in IDLE.
- Priority: if `bk_req` is high and `age`==`AGE_MAX`, bk wins. Otherwise the order is cpu > ss > bk.
- Ageing counter `age` is 3 bits, saturating at `AGE_MAX`:
  - increments on each cpu or ss grant while `bk_req` is high;
  - clears on a bk grant, or when `bk_req` is low at a grant.
- ISSUE: drive the SRAM controller for one cycle.
  - Byte ports: `mem_addr`=addr[16:1]; `mem_d`={d,d}; on a write, `mem_ub`=addr[0] and `mem_lb`=~addr[0].
  - bk port: `mem_addr`=`bk_addr`; `mem_d`=`bk_d`; on a write, `mem_ub`=`mem_lb`=1.
  - `mem_we`=latched `we`. `mem_ub`/`mem_lb` are 0 on reads.
- WAIT: `mem_we`=0; `mem_addr` holds its value.
- DONE: capture read data and pulse the winner's ack; return to IDLE.
  - Byte ports read `mem_q[15:8]` when latched addr[0]=1, else `mem_q[7:0]`.
  - The bk port reads all of `mem_q`.
  - Writes also ack; the read-data register of that port is left unchanged.
- `*_q` outputs hold their value until the next read completion on the same port.
- A request dropped mid-transaction does not abort it: the access completes and the ack still pulses.
- Back-to-back: a requester that keeps its request high after its ack is re-arbitrated in the following IDLE against the other requesters.
- Reset values: FSM=IDLE, `age`=0, all acks 0, `mem_we`/`mem_ub`/`mem_lb`=0, `mem_addr`=0, `mem_d`=0, all `*_q`=0, `busy`=0.
- Reset mid-transaction: abandon the access with no ack. A write already strobed in ISSUE is not retracted.

## Timing
- Cycle N: IDLE samples requests. N+1: ISSUE (`mem_we` pulse). N+2: WAIT. N+3: DONE (ack, `*_q` valid from N+4). N+4: IDLE.
- Request-to-ack latency is 3 cycles. Maximum throughput is one access per 4 cycles.
- All outputs are registered. `busy` is high in ISSUE, WAIT and DONE.
- For a single access, the requester drops its request on the edge following the ack. Otherwise it is sampled again in IDLE at N+4.

## Test plan
- Single CPU read, `cpu_addr`=0x00003, SRAM word 1 = 0xBEEF: `cpu_ack` at +3 cycles, `cpu_q`=0xBE, `mem_ub`=`mem_lb`=0 during the read.
- CPU write, `cpu_addr`=0x00002, `cpu_d`=0x5A: one-cycle `mem_we`, `mem_addr`=1, `mem_d`=0x5A5A, `mem_lb`=1, `mem_ub`=0. A follow-up read returns 0x5A.
- cpu, ss and bk request in the same cycle: grant order is cpu, ss, bk. Acks land on cycles 3, 7 and 11.
- cpu held high continuously with bk pending, `AGE_MAX`=4: 4 cpu grants, then a bk grant, then cpu resumes; `age` is back to 0 after the bk grant.
- bk write `bk_addr`=0x0010, `bk_d`=0x1234 followed by a bk read: `mem_ub`=`mem_lb`=1 on the write; `bk_q`=0x1234 and `bk_ack` pulses once per access.
- `reset` asserted in WAIT of a CPU read: no `cpu_ack`, all outputs are at their reset values the next cycle, and a new request is served normally.
